ddr_burst_responder: RTL and testbench



---
 rtl/ddr_burst_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_ddr_burst_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_responder.sv
// rtl/ddr_burst_responder.sv - block-RAM backed responder for the DDR user burst interface
//
// Stands in for the user side of a DDR controller. Bursts are served one at a
// time out of a 2^ADDR_W x 32 on-chip RAM. Write and read requests are
// arbitrated round-robin.
//
// Optional build macro: BURST_STATS_EN adds burst counters and an arbitration
// conflict strobe.
//
// Ports:
//   clk                  single clock for all logic and the RAM
//   rst                  synchronous active-high reset
//   local_init_done      high once the emulated calibration delay has elapsed
//   wr_burst_req         write request, held by the initiator until wr_burst_finish
//   wr_burst_addr[24:0]  write start word address (only [ADDR_W-1:0] used)
//   wr_burst_len[9:0]    write length in words
//   wr_burst_data_req    per-word request strobe to the initiator
//   wr_burst_data[31:0]  write word, presented the cycle after each strobe
//   wr_burst_finish      one-cycle pulse when a write burst completes
//   rd_burst_req         read request, held by the initiator until rd_burst_finish
//   rd_burst_addr[24:0]  read start word address (only [ADDR_W-1:0] used)
//   rd_burst_len[9:0]    read length in words
//   rd_burst_data_valid  qualifies rd_burst_data
//   rd_burst_data[31:0]  read word; holds its last value while not valid
//   rd_burst_finish      one-cycle pulse when a read burst completes
//   wr_burst_cnt[15:0]   (BURST_STATS_EN) completed write bursts, wrapping
//   rd_burst_cnt[15:0]   (BURST_STATS_EN) completed read bursts, wrapping
//   arb_conflict         (BURST_STATS_EN) pulse when both requests met at a grant

module ddr_burst_responder #(
    parameter int ADDR_W      = 12,
    parameter int INIT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic        local_init_done,
    input  logic        wr_burst_req,
    input  logic [24:0] wr_burst_addr,
    input  logic [9:0]  wr_burst_len,
    output logic        wr_burst_data_req,
    input  logic [31:0] wr_burst_data,
    output logic        wr_burst_finish,
    input  logic        rd_burst_req,
    input  logic [24:0] rd_burst_addr,
    input  logic [9:0]  rd_burst_len,
    output logic        rd_burst_data_valid,
    output logic [31:0] rd_burst_data,
    output logic        rd_burst_finish
`ifdef BURST_STATS_EN
    ,
    output logic [15:0] wr_burst_cnt,
    output logic [15:0] rd_burst_cnt,
    output logic        arb_conflict
`endif
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_WR_DATA = 3'd2;
    localparam logic [2:0] S_WR_TAIL = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RD_LAST = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;

    logic [2:0]        state;
    logic [INIT_W-1:0] init_cnt;
    logic              last_wr;      // 1: write was the most recent grant
    logic [9:0]        burst_len;
    logic [9:0]        beat_cnt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_pend;      // strobe issued last cycle, its word is on the bus now
    logic              grant_wr;
    logic              grant_rd;

    logic [31:0] mem [DEPTH];

    // Upper address bits address nothing in this RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_burst_addr[24:ADDR_W], rd_burst_addr[24:ADDR_W]};

    // Round-robin: a lone requester wins; on a tie the side not served last wins.
    assign grant_wr = (state == S_IDLE) && wr_burst_req && (!rd_burst_req || !last_wr);
    assign grant_rd = (state == S_IDLE) && rd_burst_req && !grant_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_INIT;
            init_cnt            <= '0;
            local_init_done     <= 1'b0;
            last_wr             <= 1'b0;
            burst_len           <= '0;
            beat_cnt            <= '0;
            wr_ptr              <= '0;
            rd_ptr              <= '0;
            wr_pend             <= 1'b0;
            wr_burst_data_req   <= 1'b0;
            wr_burst_finish     <= 1'b0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_finish     <= 1'b0;
        end else begin
            wr_burst_finish     <= 1'b0;
            rd_burst_finish     <= 1'b0;
            rd_burst_data_valid <= 1'b0;
            wr_pend             <= wr_burst_data_req;
            if (wr_pend) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end

            case (state)
                S_INIT: begin
                    if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                        local_init_done <= 1'b1;
                        state           <= S_IDLE;
                    end else begin
                        init_cnt <= init_cnt + INIT_W'(1);
                    end
                end

                S_IDLE: begin
                    if (grant_wr) begin
                        last_wr   <= 1'b1;
                        wr_ptr    <= wr_burst_addr[ADDR_W-1:0];
                        burst_len <= wr_burst_len;
                        if (wr_burst_len == 10'd0) begin
                            state           <= S_FINISH;
                            wr_burst_finish <= 1'b1;
                        end else begin
                            state             <= S_WR_DATA;
                            wr_burst_data_req <= 1'b1;
                            beat_cnt          <= 10'd1;   // strobes issued so far
                        end
                    end else if (grant_rd) begin
                        last_wr   <= 1'b0;
                        rd_ptr    <= rd_burst_addr[ADDR_W-1:0];
                        burst_len <= rd_burst_len;
                        if (rd_burst_len == 10'd0) begin
                            state           <= S_FINISH;
                            rd_burst_finish <= 1'b1;
                        end else begin
                            state    <= S_RD_DATA;
                            beat_cnt <= 10'd0;            // reads issued so far
                        end
                    end
                end

                S_WR_DATA: begin
                    if (beat_cnt == burst_len) begin
                        wr_burst_data_req <= 1'b0;
                        state             <= S_WR_TAIL;
                    end else begin
                        beat_cnt <= beat_cnt + 10'd1;
                    end
                end

                // The word for the final strobe lands this cycle.
                S_WR_TAIL: begin
                    state           <= S_FINISH;
                    wr_burst_finish <= 1'b1;
                end

                S_RD_DATA: begin
                    rd_burst_data_valid <= 1'b1;
                    rd_ptr              <= rd_ptr + ADDR_W'(1);
                    if (beat_cnt == burst_len - 10'd1) begin
                        state <= S_RD_LAST;
                    end else begin
                        beat_cnt <= beat_cnt + 10'd1;
                    end
                end

                // Last read word is on the output this cycle.
                S_RD_LAST: begin
                    state           <= S_FINISH;
                    rd_burst_finish <= 1'b1;
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    // RAM write port; contents survive reset, but a reset edge blocks the pending write.
    always_ff @(posedge clk) begin
        if (!rst && wr_pend) begin
            mem[wr_ptr] <= wr_burst_data;
        end
    end

    // RAM read port with one cycle of latency; the output register holds between bursts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_burst_data <= '0;
        end else if (state == S_RD_DATA) begin
            rd_burst_data <= mem[rd_ptr];
        end
    end

`ifdef BURST_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_burst_cnt <= '0;
            rd_burst_cnt <= '0;
            arb_conflict <= 1'b0;
        end else begin
            arb_conflict <= (grant_wr || grant_rd) && wr_burst_req && rd_burst_req;
            if (wr_burst_finish) begin
                wr_burst_cnt <= wr_burst_cnt + 16'd1;
            end
            if (rd_burst_finish) begin
                rd_burst_cnt <= rd_burst_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr_burst_responder.sv
// tb/tb_ddr_burst_responder.sv - scoreboard testbench for ddr_burst_responder

module tb_ddr_burst_responder;

    localparam int ADDR_W      = 12;
    localparam int INIT_CYCLES = 64;
    localparam int DEPTH       = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        local_init_done;
    logic        wr_burst_req;
    logic [24:0] wr_burst_addr;
    logic [9:0]  wr_burst_len;
    logic        wr_burst_data_req;
    logic [31:0] wr_burst_data;
    logic        wr_burst_finish;
    logic        rd_burst_req;
    logic [24:0] rd_burst_addr;
    logic [9:0]  rd_burst_len;
    logic        rd_burst_data_valid;
    logic [31:0] rd_burst_data;
    logic        rd_burst_finish;
`ifdef BURST_STATS_EN
    logic [15:0] wr_burst_cnt;
    logic [15:0] rd_burst_cnt;
    logic        arb_conflict;
`endif

    ddr_burst_responder #(.ADDR_W(ADDR_W), .INIT_CYCLES(INIT_CYCLES)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .local_init_done     (local_init_done),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish)
`ifdef BURST_STATS_EN
        ,
        .wr_burst_cnt        (wr_burst_cnt),
        .rd_burst_cnt        (rd_burst_cnt),
        .arb_conflict        (arb_conflict)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    logic [31:0] mdl [int];        // reference memory: word address -> contents
    logic [31:0] exp_rd [$];       // expected read words in delivery order
    logic [31:0] wr_word_q [$];    // words to hand out on each write strobe
    bit   [7:0]  exp_fin [$];      // expected finish order, "W" or "R"
    bit          last_wr;          // reference arbiter: write served most recently

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_write(input int addr, input int len, input logic [31:0] base, input bit rnd);
        for (int k = 0; k < len; k++) begin
            logic [31:0] w;
            w = rnd ? 32'($urandom) : base + 32'(k);
            mdl[(addr + k) % DEPTH] = w;
            wr_word_q.push_back(w);
        end
    endfunction

    function automatic void model_read(input int addr, input int len);
        for (int k = 0; k < len; k++) begin
            int a;
            a = (addr + k) % DEPTH;
            if (mdl.exists(a)) exp_rd.push_back(mdl[a]);
            else exp_rd.push_back(32'hDEAD_BEEF);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents read data or a finish.
    always @(negedge clk) begin
        if (wr_burst_data_req || rd_burst_data_valid)
            check("strobe_valid_exclusive", 32'(wr_burst_data_req & rd_burst_data_valid), 32'd0);
        if (wr_burst_finish || rd_burst_finish)
            check("finish_exclusive", 32'(wr_burst_finish & rd_burst_finish), 32'd0);
        if (rd_burst_data_valid) begin
            if (exp_rd.size() == 0) check("rd_unexpected_word", 32'd1, 32'd0);
            else check("rd_data", rd_burst_data, exp_rd.pop_front());
        end
        if (wr_burst_finish) begin
            if (exp_fin.size() == 0) check("wr_unexpected_finish", 32'd1, 32'd0);
            else check("finish_order_w", 32'("W"), 32'(exp_fin.pop_front()));
        end
        if (rd_burst_finish && !wr_burst_finish) begin
            if (exp_fin.size() == 0) check("rd_unexpected_finish", 32'd1, 32'd0);
            else check("finish_order_r", 32'("R"), 32'(exp_fin.pop_front()));
        end
    end

    // Write-data driver: the word for a strobe is presented through the following cycle.
    initial begin
        bit s;
        wr_burst_data = '0;
        forever begin
            @(negedge clk);
            s = wr_burst_data_req;
            @(posedge clk);
            #1;
            if (s) begin
                if (wr_word_q.size() == 0) check("wr_word_available", 32'd0, 32'd1);
                else wr_burst_data = wr_word_q.pop_front();
            end
        end
    end

    task automatic do_reset();
        int  zero_cnt;
        bit  early;
        bit  seen;
        @(negedge clk);
        rst = 1'b1;
        wr_burst_req = 1'b0;
        rd_burst_req = 1'b0;
        repeat (3) @(negedge clk);
        exp_rd.delete();
        exp_fin.delete();
        wr_word_q.delete();
        last_wr = 1'b0;
        rst = 1'b0;
        check("rst_init_done", 32'(local_init_done), 32'd0);
        check("rst_data_req", 32'(wr_burst_data_req), 32'd0);
        check("rst_valid", 32'(rd_burst_data_valid), 32'd0);
        check("rst_finish", 32'({wr_burst_finish, rd_burst_finish}), 32'd0);
        check("rst_rd_data", rd_burst_data, 32'd0);
`ifdef BURST_STATS_EN
        check("rst_wr_cnt", 32'(wr_burst_cnt), 32'd0);
        check("rst_rd_cnt", 32'(rd_burst_cnt), 32'd0);
        check("rst_conflict", 32'(arb_conflict), 32'd0);
`endif
        // A zero-length write raised during calibration must wait for init.
        zero_cnt = 0;
        early = 1'b0;
        while (!local_init_done && zero_cnt < 200) begin
            zero_cnt++;
            if (zero_cnt == 10) begin
                exp_fin.push_back("W");
                last_wr = 1'b1;
                wr_burst_addr = 25'h10;
                wr_burst_len = 10'd0;
                wr_burst_req = 1'b1;
            end
            @(negedge clk);
            if (!local_init_done && (wr_burst_finish || wr_burst_data_req)) early = 1'b1;
        end
        check("init_low_cycles", 32'(zero_cnt), 32'(INIT_CYCLES));
        check("no_grant_before_init", 32'(early), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            if (wr_burst_finish) seen = 1'b1;
        end
        wr_burst_req = 1'b0;
        check("grant_after_init", 32'(seen), 32'd1);
        check("init_done_held", 32'(local_init_done), 32'd1);
    endtask

    task automatic single(input bit is_wr, input int addr, input int len, input logic [31:0] base, input bit rnd);
        int first;
        int last;
        int n;
        int fin;
        bit s;
        first = -1; last = -1; n = 0; fin = -1;
        if (is_wr) begin
            model_write(addr, len, base, rnd);
            exp_fin.push_back("W");
            last_wr = 1'b1;
        end else begin
            model_read(addr, len);
            exp_fin.push_back("R");
            last_wr = 1'b0;
        end
        @(negedge clk);
        if (is_wr) begin
            wr_burst_addr = {13'($urandom), 12'(addr)};
            wr_burst_len = 10'(len);
            wr_burst_req = 1'b1;
        end else begin
            rd_burst_addr = {13'($urandom), 12'(addr)};
            rd_burst_len = 10'(len);
            rd_burst_req = 1'b1;
        end
        for (int i = 1; i <= len + 20; i++) begin
            @(negedge clk);
            s = is_wr ? wr_burst_data_req : rd_burst_data_valid;
            if (s) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
            if (is_wr ? wr_burst_finish : rd_burst_finish) begin
                fin = i;
                break;
            end
        end
        wr_burst_req = 1'b0;
        rd_burst_req = 1'b0;
        check("beat_count", 32'(n), 32'(len));
        if (len == 0) begin
            check("zero_len_finish_latency", 32'(fin), 32'd1);
        end else begin
            check("first_beat_cycle", 32'(first), is_wr ? 32'd1 : 32'd2);
            check("beats_contiguous", 32'(last - first + 1), 32'(len));
            check("finish_after_last_beat", 32'(fin), 32'(last + (is_wr ? 2 : 1)));
        end
    endtask

    task automatic both(input int waddr, input int wlen, input int raddr, input int rlen);
        bit dw;
        bit dr;
        dw = 1'b0; dr = 1'b0;
        if (!last_wr) begin
            model_write(waddr, wlen, 32'd0, 1'b1);
            exp_fin.push_back("W");
            model_read(raddr, rlen);
            exp_fin.push_back("R");
            last_wr = 1'b0;
        end else begin
            model_read(raddr, rlen);
            exp_fin.push_back("R");
            model_write(waddr, wlen, 32'd0, 1'b1);
            exp_fin.push_back("W");
            last_wr = 1'b1;
        end
        @(negedge clk);
        wr_burst_addr = {13'($urandom), 12'(waddr)};
        wr_burst_len = 10'(wlen);
        rd_burst_addr = {13'($urandom), 12'(raddr)};
        rd_burst_len = 10'(rlen);
        wr_burst_req = 1'b1;
        rd_burst_req = 1'b1;
        for (int i = 0; i < wlen + rlen + 40 && !(dw && dr); i++) begin
            @(negedge clk);
            if (wr_burst_finish) begin wr_burst_req = 1'b0; dw = 1'b1; end
            if (rd_burst_finish) begin rd_burst_req = 1'b0; dr = 1'b1; end
        end
        wr_burst_req = 1'b0;
        rd_burst_req = 1'b0;
        check("both_served", 32'(dw && dr), 32'd1);
    endtask

    task automatic reset_mid_read();
        int n;
        n = 0;
        model_read(16, 48);
        exp_fin.push_back("R");
        last_wr = 1'b0;
        @(negedge clk);
        rd_burst_addr = 25'h10;
        rd_burst_len = 10'd48;
        rd_burst_req = 1'b1;
        for (int i = 0; i < 80 && n < 20; i++) begin
            @(negedge clk);
            if (rd_burst_data_valid) n++;
        end
        check("mid_read_reached", 32'(n), 32'd20);
        rst = 1'b1;
        rd_burst_req = 1'b0;
        @(negedge clk);
        check("abort_valid_drop", 32'(rd_burst_data_valid), 32'd0);
        check("abort_no_finish", 32'(rd_burst_finish), 32'd0);
        exp_rd.delete();
        exp_fin.delete();
        do_reset();
    endtask

    initial begin
        int op;
        int l;
        int a;
        wr_burst_req = 1'b0;
        wr_burst_addr = '0;
        wr_burst_len = '0;
        rd_burst_req = 1'b0;
        rd_burst_addr = '0;
        rd_burst_len = '0;
        last_wr = 1'b0;

        do_reset();
        single(1'b1, 0, 256, 32'd0, 1'b1);           // fill the working region
        single(1'b1, 'h10, 48, 32'h1000, 1'b0);
        single(1'b0, 'h10, 48, 32'd0, 1'b0);
        single(1'b1, 'hFFE, 4, 32'hA, 1'b0);         // A,B,C,D across the wrap
        single(1'b0, 0, 2, 32'd0, 1'b0);
        single(1'b0, 'hFFE, 2, 32'd0, 1'b0);
        single(1'b1, 'h10, 0, 32'd0, 1'b0);
        single(1'b0, 'h10, 0, 32'd0, 1'b0);
        single(1'b0, 'h10, 48, 32'd0, 1'b0);
        both('h40, 8, 'h40, 8);
        both('h80, 5, 'h20, 12);
        both('h90, 0, 'h90, 3);
        for (int it = 0; it < 16; it++) begin
            op = int'($urandom_range(0, 2));
            l  = int'($urandom_range(0, 40));
            a  = int'($urandom_range(0, 255 - l));
            case (op)
                0: single(1'b1, a, l, 32'd0, 1'b1);
                1: single(1'b0, a, l, 32'd0, 1'b0);
                default: both(a, l, int'($urandom_range(0, 200)), int'($urandom_range(0, 40)));
            endcase
        end
        single(1'b1, 'h10, 48, 32'h1000, 1'b0);
        reset_mid_read();
        single(1'b0, 'h10, 48, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("scoreboard_rd_drained", 32'(exp_rd.size()), 32'd0);
        check("scoreboard_fin_drained", 32'(exp_fin.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

endmodule
